// File: rtl/cmp_sched_pkg.sv
//============================================================================
// Module      : cmp_sched_pkg
// Description : Shared types and helpers for the bit-serial compare scheduler.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cmp_sched_pkg;

  // Scheduler phases: waiting for a request, walking bits, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int NUM_REQ = 2;

  // Identifies which requester owns an operation or result.
  typedef logic [0:0] req_id_t;

  // Bit counter width; a one-bit operand still needs a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_cell_1bit.sv
//============================================================================
// Module      : cmp_cell_1bit
// Description : One stage of a cascaded less-than comparator. A differing bit
//               decides the result (a<b exactly when b is the 1); an equal
//               bit forwards the result of the lower-order bits.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cmp_cell_1bit (
  input  logic a,
  input  logic b,
  input  logic in,
  output logic w
);

  // Decide on a differing bit, otherwise pass the lower-bit verdict along.
  always_comb begin
    w = (a ^ b) ? b : in;
  end

endmodule

`default_nettype wire

// File: rtl/cmp_serial_sched.sv
//============================================================================
// Module      : cmp_serial_sched
// Description : Two-requester scheduler sharing a single 1-bit compare cell.
//               Operands are shifted LSB-first through the cell over WIDTH
//               cycles with the cascade value held in a carry flop. The
//               carry is seeded with the requester's le bit so the same
//               walk yields either a<b or a<=b.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module cmp_serial_sched
  import cmp_sched_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [WIDTH-1:0]   req_a0,
  input  logic [WIDTH-1:0]   req_b0,
  input  logic [WIDTH-1:0]   req_a1,
  input  logic [WIDTH-1:0]   req_b1,
  input  logic [NUM_REQ-1:0] req_le,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_lt,
  output logic               rsp_id,
  output logic               busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  sched_state_t     state_q, state_d;
  req_id_t          ptr_q, ptr_d;
  req_id_t          id_q, id_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_lt_q, rsp_lt_d;
  logic             rsp_id_q, rsp_id_d;

  req_id_t          grant;
  logic             accept;
  logic             cell_w;

  // The shared comparator stage, fed by the low bits of the shift registers.
  cmp_cell_1bit u_cell (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .in (carry_q),
    .w  (cell_w)
  );

  // Arbiter: a lone requester always wins, a tie goes to the pointer.
  // Ready is offered only in IDLE and is forced low while reset is held.
  always_comb begin
    grant     = ptr_q;
    req_ready = '0;
    if (req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (req_valid == 2'b10) begin
      grant = 1'b1;
    end
    if ((state_q == IDLE) && (|req_valid) && !rst) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Sequencing: capture on accept, walk one bit per cycle, hold the verdict.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    rsp_valid_d = rsp_valid_q;
    rsp_lt_d    = rsp_lt_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_sh_d  = grant[0] ? req_a1 : req_a0;
          b_sh_d  = grant[0] ? req_b1 : req_b0;
          carry_d = req_le[grant];
          cnt_d   = '0;
          id_d    = grant;
          ptr_d   = ~grant;
          state_d = RUN;
        end
      end

      RUN: begin
        carry_d = cell_w;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the verdict registered alongside the carry.
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_lt_d    = cell_w;
          rsp_id_d    = id_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_lt_q    <= rsp_lt_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_cmp_serial_sched.sv
//============================================================================
// Module      : tb_cmp_serial_sched
// Description : Self-checking bench for cmp_serial_sched (WIDTH=3 and WIDTH=1
//               instances) and the standalone compare cell.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cmp_serial_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0 drives the WIDTH=3 instance, index 1 the WIDTH=1 instance.
  logic [1:0][1:0] rv;
  logic [1:0][2:0] a0, b0, a1, b1;
  logic [1:0][1:0] le;
  logic [1:0]      rr;
  logic [1:0][1:0] o_ready;
  logic [1:0]      o_valid, o_lt, o_id, o_busy;

  logic ca, cb, cin, cw;

  int checks = 0;
  int passes = 0;

  cmp_serial_sched #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(rv[0]), .req_ready(o_ready[0]),
    .req_a0(a0[0]), .req_b0(b0[0]), .req_a1(a1[0]), .req_b1(b1[0]),
    .req_le(le[0]),
    .rsp_valid(o_valid[0]), .rsp_ready(rr[0]),
    .rsp_lt(o_lt[0]), .rsp_id(o_id[0]), .busy(o_busy[0])
  );

  cmp_serial_sched #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(rv[1]), .req_ready(o_ready[1]),
    .req_a0(a0[1][0:0]), .req_b0(b0[1][0:0]),
    .req_a1(a1[1][0:0]), .req_b1(b1[1][0:0]),
    .req_le(le[1]),
    .rsp_valid(o_valid[1]), .rsp_ready(rr[1]),
    .rsp_lt(o_lt[1]), .rsp_id(o_id[1]), .busy(o_busy[1])
  );

  cmp_cell_1bit u_cell (.a(ca), .b(cb), .in(cin), .w(cw));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end else begin
      passes++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pending operation becomes visible WIDTH edges after acceptance and
  // stays visible until the consumer takes it.
  logic m_pend [2];
  int   m_age  [2];
  logic m_res  [2];
  logic m_id   [2];
  logic m_ptr  [2];

  function automatic int wd(input int k);
    return (k == 0) ? 3 : 1;
  endfunction

  function automatic logic grant_of(input int k);
    return (rv[k] == 2'b11) ? m_ptr[k] : rv[k][1];
  endfunction

  function automatic logic [1:0] exp_ready(input int k);
    if (m_pend[k] || rv[k] == 2'b00) return 2'b00;
    if (rv[k] == 2'b11) return m_ptr[k] ? 2'b10 : 2'b01;
    return rv[k];
  endfunction

  function automatic logic ref_lt(input int k, input logic g);
    int a, b;
    a = g ? int'(a1[k]) : int'(a0[k]);
    b = g ? int'(b1[k]) : int'(b0[k]);
    a = a % (1 << wd(k));
    b = b % (1 << wd(k));
    return le[k][g] ? (a <= b) : (a < b);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_pend[k] <= 1'b0;
        m_age[k]  <= 0;
        m_res[k]  <= 1'b0;
        m_id[k]   <= 1'b0;
        m_ptr[k]  <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_pend[k]) begin
          if (m_age[k] >= wd(k) && rr[k]) m_pend[k] <= 1'b0;
          else if (m_age[k] < wd(k)) m_age[k] <= m_age[k] + 1;
        end else if (rv[k] != 2'b00) begin
          m_pend[k] <= 1'b1;
          m_age[k]  <= 0;
          m_id[k]   <= grant_of(k);
          m_ptr[k]  <= ~grant_of(k);
          m_res[k]  <= ref_lt(k, grant_of(k));
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("req_ready[%0d]", k), o_ready[k], exp_ready(k));
        chk($sformatf("rsp_valid[%0d]", k), o_valid[k], m_pend[k] && (m_age[k] >= wd(k)));
        chk($sformatf("busy[%0d]", k), o_busy[k], m_pend[k]);
        if (m_pend[k] && m_age[k] >= wd(k)) begin
          chk($sformatf("rsp_lt[%0d]", k), o_lt[k], m_res[k]);
          chk($sformatf("rsp_id[%0d]", k), o_id[k], m_id[k]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input int k, input int idx, input logic [2:0] a, input logic [2:0] b, input logic l);
    if (idx == 0) begin a0[k] = a; b0[k] = b; end
    else          begin a1[k] = a; b1[k] = b; end
    le[k][idx] = l;
    rv[k][idx] = 1'b1;
  endtask

  task automatic wait_accept(input int k, input int idx);
    int  n = 0;
    bit  got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (o_ready[k][idx]) got = 1;
      n++;
    end
    chk("accept_timeout", got, 1'b1);
    @(posedge clk);
    #1;
    rv[k][idx] = 1'b0;
  endtask

  // Called #1 after the accept edge; returns #1 after the handshake edge
  // when rsp_ready is high, otherwise at the first falling edge with a result.
  task automatic wait_resp(input int k, input logic exp_lt, input logic exp_id);
    int n = 0;
    bit got = 0;
    while (n < 40 && !got) begin
      @(negedge clk);
      if (o_valid[k]) got = 1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    chk("resp_timeout", got, 1'b1);
    chk("resp_latency", n, wd(k));
    chk("resp_lt_lit", o_lt[k], exp_lt);
    chk("resp_id_lit", o_id[k], exp_id);
    if (rr[k]) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cell_tbl;
    logic       g;
    bit         got;

    rv = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0; le = '0; rr = 2'b11;
    ca = 0; cb = 0; cin = 0;

    // Arbitration setup held during reset: ready must stay low.
    a0[0] = 3'd1; b0[0] = 3'd2; a1[0] = 3'd5; b1[0] = 3'd4;
    rv[0] = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready", o_ready[k], 2'b00);
      chk("rst_valid", o_valid[k], 1'b0);
      chk("rst_lt", o_lt[k], 1'b0);
      chk("rst_id", o_id[k], 1'b0);
      chk("rst_busy", o_busy[k], 1'b0);
    end

    // Compare cell truth table, index {a,b,in}.
    cell_tbl = 8'b1000_1110;
    for (int i = 0; i < 8; i++) begin
      {ca, cb, cin} = i[2:0];
      #1;
      chk($sformatf("cell_%0d", i), cw, cell_tbl[i]);
    end

    rst = 1'b0;

    // Both valid from reset: requester 0 first, then requester 1.
    for (int r = 0; r < 2; r++) begin
      got = 0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        if (o_ready[0] != 2'b00) got = 1;
      end
      chk("arb_timeout", got, 1'b1);
      chk("arb_onehot", o_ready[0] == 2'b11, 1'b0);
      g = o_ready[0][1];
      chk("arb_grant", g, r[0]);
      @(posedge clk);
      #1;
      rv[0][g] = 1'b0;
      wait_resp(0, (r == 0), r[0]);
    end

    // Basic and equal-operand compares.
    issue(0, 0, 3'b101, 3'b110, 1'b0); wait_accept(0, 0); wait_resp(0, 1'b1, 1'b0);
    issue(0, 0, 3'd6,   3'd2,   1'b0); wait_accept(0, 0); wait_resp(0, 1'b0, 1'b0);
    issue(0, 0, 3'b011, 3'b011, 1'b0); wait_accept(0, 0); wait_resp(0, 1'b0, 1'b0);
    issue(0, 0, 3'b011, 3'b011, 1'b1); wait_accept(0, 0); wait_resp(0, 1'b1, 1'b0);

    // Backpressure: hold the result 5 cycles while another request waits.
    rr[0] = 1'b0;
    issue(0, 0, 3'd2, 3'd7, 1'b1); wait_accept(0, 0); wait_resp(0, 1'b1, 1'b0);
    issue(0, 1, 3'd7, 3'd0, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", o_valid[0], 1'b1);
      chk("bp_lt", o_lt[0], 1'b1);
      chk("bp_id", o_id[0], 1'b0);
      chk("bp_ready", o_ready[0], 2'b00);
    end
    rr[0] = 1'b1;
    @(negedge clk);
    chk("bp_release_busy", o_busy[0], 1'b0);
    chk("bp_release_ready", o_ready[0], 2'b10);
    @(posedge clk);
    #1;
    rv[0][1] = 1'b0;
    wait_resp(0, 1'b0, 1'b1);

    // Reset during the second RUN cycle.
    issue(0, 0, 3'd4, 3'd1, 1'b0); wait_accept(0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rv[0][0] = 1'b1;
    #1;
    chk("midrst_valid", o_valid[0], 1'b0);
    chk("midrst_lt", o_lt[0], 1'b0);
    chk("midrst_id", o_id[0], 1'b0);
    chk("midrst_busy", o_busy[0], 1'b0);
    chk("midrst_ready", o_ready[0], 2'b00);
    rv[0][0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_valid", o_valid[0], 1'b0);
    end
    @(posedge clk);
    #1;
    issue(0, 1, 3'd0, 3'd7, 1'b0); wait_accept(0, 1); wait_resp(0, 1'b1, 1'b1);

    // WIDTH=1 instance: single-edge latency, every operand pair and mode.
    issue(1, 0, 3'd0, 3'd1, 1'b0); wait_accept(1, 0); wait_resp(1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      logic ia, ib, il;
      {ia, ib, il} = i[2:0];
      issue(1, int'(ia ^ ib), {2'b00, ia}, {2'b00, ib}, il);
      wait_accept(1, int'(ia ^ ib));
      wait_resp(1, il ? (ia <= ib) : (ia < ib), ia ^ ib);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
